regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between the ALU and LSU writeback paths.
- Per cycle: arbitrates valid/ready requests, applies a starvation guard for the ALU, and registers the winning write onto the register-file write interface (wen/rd/rd_data).
- Sits between the execute/memory stages and the register file.

Parameters:
XLEN, 32, data width of writeback values and register-file write data
MAX_WAIT, 4, consecutive cycles a stalled ALU request may lose before it is forced to win (1..7)
WAIT_W, 3, width of the ALU wait counter; must hold MAX_WAIT

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
wb_hold  input  1  freeze: no grants while high
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU request granted this cycle (combinational)
alu_rd  input  5  ALU destination register
alu_data  input  XLEN  ALU result
lsu_valid  input  1  LSU writeback request
lsu_ready  output  1  LSU request granted this cycle (combinational)
lsu_rd  input  5  LSU destination register
lsu_data  input  XLEN  load result
rf_wen  output  1  register-file write enable (registered)
rf_rd  output  5  register-file write address (registered)
rf_rd_data  output  XLEN  register-file write data (registered)
alu_starved  output  1  high while FSM is in PRIO_ALU
rs1, rs2  input  5 each  decode read addresses (used only with WB_BYPASS_EN)
byp1_hit, byp2_hit  output  1 each  bypass match flags
byp1_data, byp2_data  output  XLEN each  bypass data

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rf_wen=0, rf_rd=0, rf_rd_data=0.
  - Wait counter=0, FSM=PRIO_LSU.
  - alu_ready=lsu_ready=0 while rst_n low.
- Handshake:
  - A transfer occurs when valid && ready in the same cycle.
  - The requester must hold rd/data stable until ready.
  - At most one ready is high per cycle.
- Grant rules, evaluated combinationally each cycle:
  - wb_hold=1: both readies 0.
  - Else only one valid: that requester is granted.
  - Else both valid: in PRIO_LSU the LSU wins; in PRIO_ALU the ALU wins.
  - Else no grant.
- FSM, two states:
  - PRIO_LSU -> PRIO_ALU when the wait counter equals MAX_WAIT at the clock edge.
  - PRIO_ALU -> PRIO_LSU on the cycle the ALU transfer completes.
  - wb_hold does not change state.
- Wait counter:
  - +1 when alu_valid && !alu_ready && !wb_hold, saturating at MAX_WAIT.
  - Cleared on ALU transfer or when alu_valid=0.
  - Holds during wb_hold.
- Output stage, 1-cycle latency:
  - On a transfer in cycle N, in cycle N+1: rf_rd = granted rd, rf_rd_data = granted data, rf_wen = (rd != 0).
  - A write to x0 is accepted (ready asserted) but produces rf_wen=0.
  - With no transfer: rf_wen=0, and rf_rd/rf_rd_data hold their last values.
- Same rd requested by both ports in the same cycle: one write per cycle, in grant order; the loser writes later. Last writer wins in the register file.
- Reset mid-operation:
  - Any pending (un-granted) request is not captured.
  - The registered write in flight is dropped (rf_wen forced to 0).
  - Requesters re-present their requests after reset.
- No combinational path from rf_* back to the readies.

Optional Feature:
- Macro: WB_BYPASS_EN
- Defined:
  - bypX_hit = rf_wen && (rf_rd == rsX), combinational from the output register.
  - bypX_data = rf_rd_data.
  - Lets decode see a write one cycle before it is readable from the register file.
- Undefined:
  - byp*_hit = 0 and byp*_data = 0 constantly.
  - rs1/rs2 are ignored.

Test Plan:
- Reset, then ALU only, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1 the same cycle; next cycle rf_wen=1, rf_rd=5, rf_rd_data=0xDEADBEEF.
- Both valid (ALU rd=3 data=0x11, LSU rd=4 data=0x22), LSU held valid continuously with new rd each cycle -> LSU wins for 4 cycles, alu_starved=1, ALU wins in cycle 5; rf_rd=3 in cycle 6.
- LSU rd=0, data=0xFFFFFFFF -> lsu_ready=1; next cycle rf_wen=0.
- wb_hold=1 for 3 cycles with both valid -> both readies 0, rf_wen=0, wait counter frozen; release -> LSU granted first.
- Drop rst_n for 1 cycle while a transfer is in flight (rf_wen=1 pending) -> rf_wen=0, rf_rd=0 immediately (asynchronous); FSM=PRIO_LSU after release.
- With WB_BYPASS_EN: ALU writes rd=7 data=0x1234, rs1=7, rs2=8 -> next cycle byp1_hit=1, byp1_data=0x1234, byp2_hit=0. Without the macro: both hits stay 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single register-file write port between the
// ALU and LSU writeback paths.
//   - Combinational valid/ready arbitration: LSU normally wins a tie. An ALU
//     request that keeps losing is promoted after MAX_WAIT lost cycles.
//   - The winning write is registered onto rf_wen/rf_rd/rf_rd_data with one
//     cycle of latency.
//   - Optional macro WB_BYPASS_EN adds decode bypass flags and data, taken
//     from the output register.
module regfile_wb_arbiter #(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = 4,
   parameter int WAIT_W   = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wb_hold,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   output logic            rf_wen,
   output logic [4:0]      rf_rd,
   output logic [XLEN-1:0] rf_rd_data,
   output logic            alu_starved,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   output logic            byp1_hit,
   output logic            byp2_hit,
   output logic [XLEN-1:0] byp1_data,
   output logic [XLEN-1:0] byp2_data
);

   typedef enum logic {PRIO_LSU = 1'b0, PRIO_ALU = 1'b1} state_e;

   localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

   state_e            state_q;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              alu_gnt, lsu_gnt;
   logic              rf_wen_q;
   logic [4:0]        rf_rd_q;
   logic [XLEN-1:0]   rf_data_q;

   // Grant selection: only register state and inputs feed this, never rf_*.
   always_comb begin
      alu_gnt = 1'b0;
      lsu_gnt = 1'b0;
      if (rst_n && !wb_hold) begin
         if (alu_valid && lsu_valid) begin
            alu_gnt = (state_q == PRIO_ALU);
            lsu_gnt = (state_q != PRIO_ALU);
         end else begin
            alu_gnt = alu_valid;
            lsu_gnt = lsu_valid;
         end
      end
   end

   assign alu_ready = alu_gnt;
   assign lsu_ready = lsu_gnt;

   // ALU loss counter: frozen under hold, cleared when the ALU is idle or wins.
   always_comb begin
      wait_d = wait_q;
      if (!wb_hold) begin
         if (!alu_valid || alu_gnt)
            wait_d = '0;
         else if (wait_q != MAX_WAIT_C)
            wait_d = wait_q + WAIT_W'(1);
      end
   end

   // Priority FSM. Promotion happens on the edge where the counter reaches
   // MAX_WAIT, so the ALU wins on the cycle right after its MAX_WAIT-th loss.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= PRIO_LSU;
         wait_q      <= '0;
         alu_starved <= 1'b0;
      end else begin
         wait_q <= wait_d;
         if (!wb_hold) begin
            case (state_q)
               PRIO_LSU: if (wait_d == MAX_WAIT_C) begin
                  state_q     <= PRIO_ALU;
                  alu_starved <= 1'b1;
               end
               PRIO_ALU: if (alu_gnt) begin
                  state_q     <= PRIO_LSU;
                  alu_starved <= 1'b0;
               end
               default: begin
                  state_q     <= PRIO_LSU;
                  alu_starved <= 1'b0;
               end
            endcase
         end
      end
   end

   // Writeback register: capture the winner. Writes to x0 are swallowed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_wen_q  <= 1'b0;
         rf_rd_q   <= '0;
         rf_data_q <= '0;
      end else if (alu_gnt) begin
         rf_wen_q  <= |alu_rd;
         rf_rd_q   <= alu_rd;
         rf_data_q <= alu_data;
      end else if (lsu_gnt) begin
         rf_wen_q  <= |lsu_rd;
         rf_rd_q   <= lsu_rd;
         rf_data_q <= lsu_data;
      end else begin
         rf_wen_q  <= 1'b0;
      end
   end

   assign rf_wen     = rf_wen_q;
   assign rf_rd      = rf_rd_q;
   assign rf_rd_data = rf_data_q;

`ifdef WB_BYPASS_EN
   // Decode sees the in-flight write one cycle before the register file does.
   assign byp1_hit  = rf_wen_q && (rf_rd_q == rs1);
   assign byp2_hit  = rf_wen_q && (rf_rd_q == rs2);
   assign byp1_data = rf_data_q;
   assign byp2_data = rf_data_q;
`else
   logic unused_rs;
   assign unused_rs = ^{rs1, rs2};
   assign byp1_hit  = 1'b0;
   assign byp2_hit  = 1'b0;
   assign byp1_data = '0;
   assign byp2_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations,
// then randomized requesters, all checked every cycle against a behavioural
// model of the arbitration rules.
module tb_regfile_wb_arbiter;
   localparam int XLEN     = 32;
   localparam int MAX_WAIT = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            wb_hold = 1'b0;
   logic            alu_valid = 1'b0, lsu_valid = 1'b0;
   logic [4:0]      alu_rd = '0, lsu_rd = '0, rs1 = '0, rs2 = '0;
   logic [XLEN-1:0] alu_data = '0, lsu_data = '0;
   logic            alu_ready, lsu_ready, rf_wen, alu_starved, byp1_hit, byp2_hit;
   logic [4:0]      rf_rd;
   logic [XLEN-1:0] rf_rd_data, byp1_data, byp2_data;

   regfile_wb_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT), .WAIT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .wb_hold(wb_hold),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_rd_data(rf_rd_data), .alu_starved(alu_starved),
      .rs1(rs1), .rs2(rs2), .byp1_hit(byp1_hit), .byp2_hit(byp2_hit),
      .byp1_data(byp1_data), .byp2_data(byp2_data)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Model state: consecutive ALU losses, ALU-priority flag, last committed write.
   int          m_losses;
   bit          m_prio_alu;
   bit          m_wen;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   bit          g_alu, g_lsu;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_losses = 0; m_prio_alu = 0; m_wen = 0; m_rd = '0; m_data = '0;
      g_alu = 0; g_lsu = 0;
   endtask

   // Expected grants for the current inputs, then every output compared.
   task automatic compare();
      bit e1, e2;
      logic [31:0] ed;
      g_alu = 0; g_lsu = 0;
      if (rst_n && !wb_hold) begin
         if (alu_valid && lsu_valid) begin
            g_alu = m_prio_alu;
            g_lsu = !m_prio_alu;
         end else begin
            g_alu = alu_valid;
            g_lsu = lsu_valid;
         end
      end
`ifdef WB_BYPASS_EN
      e1 = m_wen && (m_rd == rs1);
      e2 = m_wen && (m_rd == rs2);
      ed = m_data;
`else
      e1 = 0; e2 = 0; ed = '0;
`endif
      chk("alu_ready", alu_ready, g_alu);
      chk("lsu_ready", lsu_ready, g_lsu);
      chk("rf_wen", rf_wen, m_wen);
      chk("rf_rd", rf_rd, m_rd);
      chk("rf_rd_data", rf_rd_data, m_data);
      chk("alu_starved", alu_starved, m_prio_alu);
      chk("byp1_hit", byp1_hit, e1);
      chk("byp2_hit", byp2_hit, e2);
      chk("byp1_data", byp1_data, ed);
      chk("byp2_data", byp2_data, ed);
   endtask

   // What the coming clock edge must do.
   task automatic model_advance();
      if (!wb_hold) begin
         if (!alu_valid || g_alu) m_losses = 0;
         else if (m_losses < MAX_WAIT) m_losses++;
         if (m_prio_alu && g_alu) m_prio_alu = 0;
         else if (!m_prio_alu && m_losses == MAX_WAIT) m_prio_alu = 1;
      end
      if (g_alu) begin
         m_wen = (alu_rd != 0); m_rd = alu_rd; m_data = alu_data;
      end else if (g_lsu) begin
         m_wen = (lsu_rd != 0); m_rd = lsu_rd; m_data = lsu_data;
      end else begin
         m_wen = 0;
      end
   endtask

   task automatic step(input logic h, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
      @(negedge clk);
      wb_hold = h; alu_valid = av; alu_rd = ard; alu_data = ad;
      lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
      #1;
      compare();
      model_advance();
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   logic        av, lv, h;
   logic [4:0]  ard, lrd;
   logic [31:0] ad, ld;
   int          pa, pl;

   initial begin
      model_reset();
      // Reset state with requests present: nothing granted, outputs cleared.
      @(negedge clk);
      alu_valid = 1; lsu_valid = 1; alu_rd = 5'd9; lsu_rd = 5'd10;
      #1;
      chk("rst alu_ready", alu_ready, 0);
      chk("rst lsu_ready", lsu_ready, 0);
      chk("rst rf_wen", rf_wen, 0);
      chk("rst rf_rd", rf_rd, 0);
      chk("rst rf_rd_data", rf_rd_data, 0);
      chk("rst alu_starved", alu_starved, 0);
      @(negedge clk);
      rst_n = 1; alu_valid = 0; lsu_valid = 0;

      // ALU alone: same-cycle ready, one-cycle writeback.
      step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
      chk("alu only ready", alu_ready, 1);
      idle();
      chk("alu wb wen", rf_wen, 1);
      chk("alu wb rd", rf_rd, 5);
      chk("alu wb data", rf_rd_data, 32'hDEADBEEF);

      // Starvation: LSU wins 4 cycles, ALU wins the 5th.
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 3, 32'h11, 1, 5'(4 + i), 32'h22);
         chk("starve lsu_ready", lsu_ready, 1);
         chk("starve alu_ready", alu_ready, 0);
      end
      step(0, 1, 3, 32'h11, 1, 8, 32'h22);
      chk("starve alu wins", alu_ready, 1);
      chk("starve flag", alu_starved, 1);
      step(0, 0, 0, 0, 1, 8, 32'h22);
      chk("starve wb rd", rf_rd, 3);
      chk("starve wb data", rf_rd_data, 32'h11);
      chk("starve flag clear", alu_starved, 0);
      idle();

      // Write to x0: accepted but no write enable.
      step(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF);
      chk("x0 lsu_ready", lsu_ready, 1);
      idle();
      chk("x0 rf_wen", rf_wen, 0);

      // Hold freezes grants and the loss counter.
      step(0, 1, 10, 32'hA, 1, 11, 32'hB);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 10, 32'hA, 1, 12, 32'hC);
         chk("hold alu_ready", alu_ready, 0);
         chk("hold lsu_ready", lsu_ready, 0);
         if (i > 0) chk("hold rf_wen", rf_wen, 0);
      end
      step(0, 1, 10, 32'hA, 1, 12, 32'hC);
      chk("release lsu first", lsu_ready, 1);
      step(0, 1, 10, 32'hA, 1, 13, 32'hD);
      step(0, 1, 10, 32'hA, 1, 14, 32'hE);
      step(0, 1, 10, 32'hA, 1, 15, 32'hF);
      chk("post-hold alu wins", alu_ready, 1);
      idle();
      idle();

      // Reset while in PRIO_ALU with an LSU write in flight.
      for (int i = 0; i < 4; i++) step(0, 1, 3, 32'h11, 1, 5'(20 + i), 32'h77);
      @(posedge clk); #1;
      chk("pre-rst rf_wen", rf_wen, 1);
      chk("pre-rst starved", alu_starved, 1);
      rst_n = 0;
      #1;
      chk("async rf_wen", rf_wen, 0);
      chk("async rf_rd", rf_rd, 0);
      chk("async rf_rd_data", rf_rd_data, 0);
      chk("async starved", alu_starved, 0);
      chk("async alu_ready", alu_ready, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1; alu_valid = 0; lsu_valid = 0;
      step(0, 1, 3, 32'h11, 1, 24, 32'h88);
      chk("after rst lsu wins", lsu_ready, 1);
      idle();

      // Bypass from the output register.
      rs1 = 7; rs2 = 8;
      step(0, 1, 7, 32'h1234, 0, 0, 0);
      idle();
`ifdef WB_BYPASS_EN
      chk("byp1 hit", byp1_hit, 1);
      chk("byp1 data", byp1_data, 32'h1234);
`else
      chk("byp1 hit", byp1_hit, 0);
      chk("byp1 data", byp1_data, 0);
`endif
      chk("byp2 hit", byp2_hit, 0);

      // Randomized requesters that hold their request until granted.
      av = 0; lv = 0; ard = 0; lrd = 0; ad = 0; ld = 0;
      g_alu = 0; g_lsu = 0;
      for (int c = 0; c < 3000; c++) begin
         case ((c / 500) % 3)
            0: begin pa = 50; pl = 50; end
            1: begin pa = 80; pl = 95; end
            default: begin pa = 95; pl = 30; end
         endcase
         if (!av || g_alu) begin
            av = ($urandom_range(0, 99) < pa);
            ard = 5'($urandom_range(0, 7));
            ad = $urandom;
         end
         if (!lv || g_lsu) begin
            lv = ($urandom_range(0, 99) < pl);
            lrd = 5'($urandom_range(0, 7));
            ld = $urandom;
         end
         h = ($urandom_range(0, 9) == 0);
         rs1 = 5'($urandom_range(0, 7));
         rs2 = 5'($urandom_range(0, 7));
         step(h, av, ard, ad, lv, lrd, ld);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
